// File: rtl/dmem_responder.sv
// dmem_responder: target side of the core's load/store data bus.
// Accepts one request at a time and performs an RV32I byte, half or word
// load or store on a word-organised array. It inserts LATENCY wait states
// and then returns load data, or a store acknowledge, with an error flag.
//
// Handshake rules (both channels):
//   A transfer happens on a rising edge where valid && ready are both high.
//   The request channel is ready only in IDLE. req_* is sampled only on the
//   accepting edge. The response channel holds rsp_valid, rsp_rdata and
//   rsp_error stable until the edge where rsp_ready is also high.
//   valid never waits on ready, and ready never waits on valid.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [1:0]  dbg_state
);

    localparam int unsigned AW           = $clog2(DEPTH_WORDS);
    localparam logic [32:0] WINDOW_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  LAT          = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  count;
    logic        cap_write;
    logic [2:0]  cap_funct3;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    // Array contents are deliberately left without a reset.
    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   offset;
    logic          in_window;
    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic          funct3_ok;
    logic          misaligned;
    logic          acc_error;
    logic [31:0]   rd_word;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic [31:0]   load_data;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic          commit;
    logic          do_store;

    // The offset wraps at 32 bits, so addresses below BASE_ADDR land far outside the window.
    assign offset    = cap_addr - BASE_ADDR;
    assign in_window = {1'b0, offset} < WINDOW_BYTES;
    assign word_idx  = offset[AW+1:2];
    assign lane      = offset[1:0];
    assign rd_word   = mem[word_idx];
    assign sel_byte  = rd_word[{lane, 3'b000} +: 8];
    assign sel_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];

    // Decode legality and alignment of the captured request.
    always_comb begin
        funct3_ok  = 1'b0;
        misaligned = 1'b0;
        if (cap_write) begin
            funct3_ok = (cap_funct3 == 3'b000) || (cap_funct3 == 3'b001) ||
                        (cap_funct3 == 3'b010);
        end else begin
            funct3_ok = (cap_funct3 == 3'b000) || (cap_funct3 == 3'b001) ||
                        (cap_funct3 == 3'b010) || (cap_funct3 == 3'b100) ||
                        (cap_funct3 == 3'b101);
        end
        if (cap_funct3[1:0] == 2'b01) begin
            misaligned = lane[0];
        end else if (cap_funct3[1:0] == 2'b10) begin
            misaligned = (lane != 2'b00);
        end
        acc_error = !in_window || !funct3_ok || misaligned;
    end

    // Extend the selected byte or half to 32 bits for loads.
    always_comb begin
        load_data = 32'h0;
        case (cap_funct3)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'h0, sel_byte};
            3'b101:  load_data = {16'h0, sel_half};
            default: load_data = 32'h0;
        endcase
    end

    // Replicate the right-aligned store data across lanes and build byte enables.
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = cap_wdata;
        case (cap_funct3)
            3'b000: begin
                wr_data = {4{cap_wdata[7:0]}};
                wr_be   = 4'b0001 << lane;
            end
            3'b001: begin
                wr_data = {2{cap_wdata[15:0]}};
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                wr_data = cap_wdata;
                wr_be   = 4'b1111;
            end
            default: begin
                wr_data = cap_wdata;
                wr_be   = 4'b0000;
            end
        endcase
    end

    // The access executes on the last WAIT edge. A reset during WAIT forces IDLE,
    // so a pending store never reaches the array.
    assign commit   = (state == S_WAIT) && (count == 4'd0);
    assign do_store = commit && cap_write && !acc_error;

    // Byte-enabled write into the array; lanes that are not written keep their value.
    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[word_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Request/response FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_error  <= 1'b0;
            count      <= 4'd0;
            cap_write  <= 1'b0;
            cap_funct3 <= 3'b000;
            cap_addr   <= 32'h0;
            cap_wdata  <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        cap_write  <= req_write;
                        cap_funct3 <= req_funct3;
                        cap_addr   <= req_addr;
                        cap_wdata  <= req_wdata;
                        count      <= LAT;
                        req_ready  <= 1'b0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (count == 4'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_error <= acc_error;
                        rsp_rdata <= (acc_error || cap_write) ? 32'h0 : load_data;
                        state     <= S_RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                S_RESP: begin
                    // The return to IDLE leaves a one-cycle bubble before the next accept.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder.
// Unit 0: LATENCY=2, BASE=0, 64 words.
// Unit 1: LATENCY=0, BASE=0x100, 16 words.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int BUDGET = 40;

    logic        clk;
    logic        reset_n    [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_error  [2];
    logic [1:0]  dbg_state  [2];

    int pass_cnt;
    int total_cnt;

    // Each entry is {error, rdata}.
    logic [32:0] exp_q [$];

    logic [31:0] mdl0 [64];
    logic [31:0] mdl1 [16];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .LATENCY(2)) u0 (
        .clk(clk), .reset_n(reset_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_error(rsp_error[0]), .dbg_state(dbg_state[0])
    );

    dmem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h100), .LATENCY(0)) u1 (
        .clk(clk), .reset_n(reset_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_error(rsp_error[1]), .dbg_state(dbg_state[1])
    );

    // ---------------- reference model ----------------
    function automatic logic [32:0] model_op(input int u, input bit wr, input logic [2:0] f3,
                                             input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] off;
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        int          depth;
        int          idx;
        int          ln;
        bit          err;
        depth = (u == 0) ? 64 : 16;
        off   = addr - ((u == 0) ? 32'h0 : 32'h100);
        err   = 1'b0;
        if (off >= 32'(depth * 4)) err = 1'b1;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) err = 1'b1;
        if (!wr && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) err = 1'b1;
        if (f3[1:0] == 2'b01 && off[0]) err = 1'b1;
        if (f3[1:0] == 2'b10 && off[1:0] != 2'b00) err = 1'b1;
        if (err) return {1'b1, 32'h0};
        idx = int'(off >> 2);
        ln  = int'(off[1:0]);
        w   = (u == 0) ? mdl0[idx] : mdl1[idx];
        if (wr) begin
            if (f3 == 3'd0) w[ln*8 +: 8] = wd[7:0];
            else if (f3 == 3'd1) w[ln*8 +: 16] = wd[15:0];
            else w = wd;
            if (u == 0) mdl0[idx] = w;
            else mdl1[idx] = w;
            return {1'b0, 32'h0};
        end
        b = w[ln*8 +: 8];
        h = w[ln*8 +: 16];
        case (f3)
            3'd0:    return {1'b0, {24{b[7]}}, b};
            3'd1:    return {1'b0, {16{h[15]}}, h};
            3'd4:    return {1'b0, 24'h0, b};
            3'd5:    return {1'b0, 16'h0, h};
            default: return {1'b0, w};
        endcase
    endfunction

    // ---------------- driver ----------------
    // Issues one request, checks the response latency, then pops the scoreboard and compares.
    task automatic xact(input int u, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err);
        logic [32:0] exp;
        int k;
        exp_q.push_back(model_op(u, wr, f3, addr, wd));
        rd  = 32'h0;
        err = 1'b0;
        @(negedge clk);
        req_valid[u]  = 1'b1;
        req_write[u]  = wr;
        req_funct3[u] = f3;
        req_addr[u]   = addr;
        req_wdata[u]  = wd;
        k = 0;
        while (!req_ready[u] && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready[u]) begin
            total_cnt++;
            $display("FAIL accept_timeout u%0d addr=%h: req_ready stayed 0", u, addr);
            req_valid[u] = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        @(posedge clk);
        #1;
        // Junk on req_* after acceptance must be ignored.
        req_valid[u] = 1'b0;
        req_addr[u]  = $urandom;
        req_wdata[u] = $urandom;
        k = 0;
        while (!rsp_valid[u] && k < BUDGET) begin
            @(posedge clk);
            #1;
            k++;
        end
        total_cnt++;
        if (k !== ((u == 0) ? 3 : 1)) begin
            $display("FAIL latency u%0d addr=%h: got %0d cycles, want %0d", u, addr, k,
                     (u == 0) ? 3 : 1);
        end else begin
            pass_cnt++;
        end
        exp = exp_q.pop_front();
        if (!rsp_valid[u]) return;
        rd  = rsp_rdata[u];
        err = rsp_error[u];
        total_cnt++;
        if ({err, rd} !== exp) begin
            $display("FAIL scoreboard u%0d wr=%0d f3=%0d addr=%h: got err=%0d rdata=%h, want err=%0d rdata=%h",
                     u, wr, f3, addr, err, rd, exp[32], exp[31:0]);
        end else begin
            pass_cnt++;
        end
        rsp_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[u] = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            reset_n[u] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            total_cnt++;
            if (rsp_valid[u] !== 1'b0 || rsp_rdata[u] !== 32'h0 || rsp_error[u] !== 1'b0 ||
                dbg_state[u] !== 2'd0) begin
                $display("FAIL reset_state u%0d: valid=%0d rdata=%h err=%0d state=%0d, want 0/0/0/0",
                         u, rsp_valid[u], rsp_rdata[u], rsp_error[u], dbg_state[u]);
            end else begin
                pass_cnt++;
            end
            reset_n[u] = 1'b1;
        end
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            total_cnt++;
            if (req_ready[u] !== 1'b1) begin
                $display("FAIL reset_ready u%0d: got %0d, want 1", u, req_ready[u]);
            end else begin
                pass_cnt++;
            end
        end
    endtask

    task automatic test_word();
        logic [31:0] rd;
        logic err;
        xact(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, rd, err);
        total_cnt++;
        if (err !== 1'b0) $display("FAIL sw_error: got %0d, want 0", err);
        else pass_cnt++;
        xact(0, 0, 3'd2, 32'h10, 32'h0, rd, err);
        total_cnt++;
        if (rd !== 32'hDEADBEEF) $display("FAIL lw_data: got %h, want deadbeef", rd);
        else pass_cnt++;
    endtask

    task automatic test_byte();
        logic [31:0] rd;
        logic err;
        xact(0, 1, 3'd0, 32'h11, 32'h000000A5, rd, err);
        xact(0, 0, 3'd0, 32'h11, 32'h0, rd, err);
        total_cnt++;
        if (rd !== 32'hFFFFFFA5) $display("FAIL lb_sext: got %h, want ffffffa5", rd);
        else pass_cnt++;
        xact(0, 0, 3'd4, 32'h11, 32'h0, rd, err);
        total_cnt++;
        if (rd !== 32'h000000A5) $display("FAIL lbu_zext: got %h, want 000000a5", rd);
        else pass_cnt++;
        xact(0, 0, 3'd2, 32'h10, 32'h0, rd, err);
        total_cnt++;
        if (rd !== 32'hDEADA5EF) $display("FAIL sb_merge: got %h, want deada5ef", rd);
        else pass_cnt++;
    endtask

    task automatic test_half();
        logic [31:0] rd;
        logic err;
        xact(0, 1, 3'd2, 32'h20, 32'h12345678, rd, err);
        xact(0, 1, 3'd1, 32'h22, 32'h00008001, rd, err);
        xact(0, 0, 3'd1, 32'h22, 32'h0, rd, err);
        total_cnt++;
        if (rd !== 32'hFFFF8001) $display("FAIL lh_sext: got %h, want ffff8001", rd);
        else pass_cnt++;
        xact(0, 0, 3'd5, 32'h22, 32'h0, rd, err);
        total_cnt++;
        if (rd !== 32'h00008001) $display("FAIL lhu_zext: got %h, want 00008001", rd);
        else pass_cnt++;
        xact(0, 0, 3'd2, 32'h20, 32'h0, rd, err);
        total_cnt++;
        if (rd !== 32'h80015678) $display("FAIL sh_merge: got %h, want 80015678", rd);
        else pass_cnt++;
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic err;
        logic [31:0] e_addr [5];
        logic [2:0]  e_f3   [5];
        bit          e_wr   [5];
        e_addr = '{32'h13, 32'h21, 32'h100, 32'h10, 32'h20};
        e_f3   = '{3'd2, 3'd1, 3'd2, 3'd3, 3'd3};
        e_wr   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            xact(0, e_wr[i], e_f3[i], e_addr[i], 32'hFFFFFFFF, rd, err);
            total_cnt++;
            if (err !== 1'b1 || rd !== 32'h0) begin
                $display("FAIL err_case%0d: got err=%0d rdata=%h, want err=1 rdata=0", i, err, rd);
            end else begin
                pass_cnt++;
            end
        end
        xact(0, 0, 3'd2, 32'h20, 32'h0, rd, err);
        total_cnt++;
        if (rd !== 32'h80015678) $display("FAIL err_reread20: got %h, want 80015678", rd);
        else pass_cnt++;
        xact(0, 0, 3'd2, 32'h10, 32'h0, rd, err);
        total_cnt++;
        if (rd !== 32'hDEADA5EF) $display("FAIL err_reread10: got %h, want deada5ef", rd);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic err;
        int k;
        xact(0, 1, 3'd2, 32'h30, 32'hCAFEF00D, rd, err);
        @(negedge clk);
        req_valid[0]  = 1'b1;
        req_write[0]  = 1'b0;
        req_funct3[0] = 3'd2;
        req_addr[0]   = 32'h30;
        @(posedge clk);
        #1;
        // This store is offered while the responder is busy and must never be accepted.
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h10;
        req_wdata[0] = 32'h11111111;
        k = 0;
        while (!rsp_valid[0] && k < BUDGET) begin
            @(posedge clk);
            #1;
            k++;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total_cnt++;
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hCAFEF00D || req_ready[0] !== 1'b0) begin
                $display("FAIL hold_cycle%0d: valid=%0d rdata=%h ready=%0d, want 1/cafef00d/0",
                         c, rsp_valid[0], rsp_rdata[0], req_ready[0]);
            end else begin
                pass_cnt++;
            end
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[0] = 1'b0;
        total_cnt++;
        if (rsp_valid[0] !== 1'b0 || dbg_state[0] !== 2'd0 || req_ready[0] !== 1'b1) begin
            $display("FAIL hold_release: valid=%0d state=%0d ready=%0d, want 0/0/1",
                     rsp_valid[0], dbg_state[0], req_ready[0]);
        end else begin
            pass_cnt++;
        end
        xact(0, 0, 3'd2, 32'h10, 32'h0, rd, err);
        total_cnt++;
        if (rd !== 32'hDEADA5EF) $display("FAIL hold_no_accept: got %h, want deada5ef", rd);
        else pass_cnt++;
    endtask

    // Resets unit u while a store is in WAIT; the store must be dropped.
    task automatic reset_in_wait(input int u, input logic [31:0] addr);
        @(negedge clk);
        req_valid[u]  = 1'b1;
        req_write[u]  = 1'b1;
        req_funct3[u] = 3'd2;
        req_addr[u]   = addr;
        req_wdata[u]  = 32'h0BADC0DE;
        @(posedge clk);
        #1;
        req_valid[u] = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (dbg_state[u] !== 2'd1) $display("FAIL rst_pre_wait u%0d: state=%0d, want 1", u, dbg_state[u]);
        else pass_cnt++;
        reset_n[u] = 1'b0;
        #1;
        total_cnt++;
        if (rsp_valid[u] !== 1'b0 || dbg_state[u] !== 2'd0) begin
            $display("FAIL rst_async u%0d: valid=%0d state=%0d, want 0/0", u, rsp_valid[u], dbg_state[u]);
        end else begin
            pass_cnt++;
        end
        @(negedge clk);
        reset_n[u] = 1'b1;
        #1;
        total_cnt++;
        if (req_ready[u] !== 1'b1) $display("FAIL rst_ready u%0d: got %0d, want 1", u, req_ready[u]);
        else pass_cnt++;
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd;
        logic err;
        reset_in_wait(0, 32'h30);
        xact(0, 0, 3'd2, 32'h30, 32'h0, rd, err);
        total_cnt++;
        if (rd !== 32'hCAFEF00D) $display("FAIL rst_drop_store: got %h, want cafef00d", rd);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic err;
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin
            xact(1, 1, 3'd2, 32'h100 + 32'(i * 4), $urandom, rd, err);
        end
        reset_in_wait(1, 32'h108);
        xact(1, 0, 3'd2, 32'h108, 32'h0, rd, err);
        for (int i = 0; i < 40; i++) begin
            a = 32'h0F8 + 32'($urandom_range(0, 80));
            xact(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, rd, err);
        end
        // Wrapped offset from an address below the window.
        xact(1, 0, 3'd2, 32'h0FC, 32'h0, rd, err);
        total_cnt++;
        if (err !== 1'b1) $display("FAIL below_window: got err=%0d, want 1", err);
        else pass_cnt++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        for (int u = 0; u < 2; u++) begin
            reset_n[u]    = 1'b0;
            req_valid[u]  = 1'b0;
            req_write[u]  = 1'b0;
            req_funct3[u] = 3'd0;
            req_addr[u]   = 32'h0;
            req_wdata[u]  = 32'h0;
            rsp_ready[u]  = 1'b0;
        end
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_backpressure();
        test_reset_wait();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
